dsp_slot_rd_sched: RTL and testbench

//  Per-slot read sequencer driving the DSP-FPGA slot interface of dsp_fpga_top. On each slot start it

---
 rtl/dsp_sched_pkg.sv | 25 ++
 rtl/dsp_rd_burst_gen.sv | 61 ++++++
 rtl/dsp_slot_rd_sched.sv | 150 +++++++++++++++
 tb/tb_dsp_slot_rd_sched.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_sched_pkg.sv
// Shared constants for the slot read sequencer: parameter defaults, FSM state
// encodings and the phase-selection helper used when a phase begins or ends.
package dsp_sched_pkg;

   localparam int DEF_ADDR_W   = 10;
   localparam int DEF_RD_GAP   = 4;
   localparam int DEF_IRQ_LEAD = 8;

   typedef logic [2:0] sched_state_t;

   localparam sched_state_t ST_IDLE    = 3'd0;
   localparam sched_state_t ST_IRQ     = 3'd1;
   localparam sched_state_t ST_LEAD    = 3'd2;
   localparam sched_state_t ST_TX_DATA = 3'd3;
   localparam sched_state_t ST_TX_FREQ = 3'd4;
   localparam sched_state_t ST_RX_FREQ = 3'd5;

   // First phase that still has words to read; ST_IDLE means the slot is finished.
   function automatic sched_state_t first_phase(input logic is_tx, input logic data_nz,
                                                input logic freq_nz, input logic rx_nz);
      if (is_tx) return data_nz ? ST_TX_DATA : (freq_nz ? ST_TX_FREQ : ST_IDLE);
      return rx_nz ? ST_RX_FREQ : ST_IDLE;
   endfunction

endpackage

// File: rtl/dsp_rd_burst_gen.sv
// Paced read burst generator: one strobe every RD_GAP cycles over addresses 0..len-1,
// then o_done one cycle before the next free strobe slot so a follow-on burst keeps cadence.
module dsp_rd_burst_gen #(
   parameter int ADDR_W = 10,
   parameter int RD_GAP = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_abort,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_len,
   output logic              o_strobe,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_done
);

   localparam int GAP_W = (RD_GAP > 1) ? $clog2(RD_GAP) : 1;

   logic              r_run;
   logic              r_tail;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_len;
   logic [GAP_W-1:0]  r_gap;
   logic              w_last;

   assign o_strobe = r_run && (r_gap == '0);
   assign w_last   = o_strobe && (r_addr == r_len - ADDR_W'(1));
   assign o_addr   = o_strobe ? r_addr : '0;
   // With a gap of one the next slot is the very next cycle, so done coincides with the last strobe.
   assign o_done   = (RD_GAP == 1) ? w_last : (r_tail && (r_gap == GAP_W'(1)));

   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (i_rst || i_abort) begin
         r_run  <= 1'b0;
         r_tail <= 1'b0;
         r_addr <= '0;
         r_len  <= '0;
         r_gap  <= '0;
      end else if (i_start) begin
         r_run  <= (i_len != '0);
         r_tail <= 1'b0;
         r_addr <= '0;
         r_len  <= i_len;
         r_gap  <= '0;
      end else if (o_strobe) begin
         r_gap <= GAP_W'(RD_GAP - 1);
         if (w_last) begin
            r_run  <= 1'b0;
            r_tail <= (RD_GAP > 1);
            r_addr <= '0;
         end else begin
            r_addr <= r_addr + ADDR_W'(1);
         end
      end else if (r_run || r_tail) begin
         r_gap <= r_gap - GAP_W'(1);
         if (r_tail && (r_gap == GAP_W'(1))) r_tail <= 1'b0;
      end
   end

endmodule

// File: rtl/dsp_slot_rd_sched.sv
// Per-slot read sequencer: slot interrupt, lead time, then paced bursts over the TX data /
// TX freq-hop tables or the RX freq/PN table through one shared burst generator.
module dsp_slot_rd_sched
   import dsp_sched_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int RD_GAP   = DEF_RD_GAP,
   parameter int IRQ_LEAD = DEF_IRQ_LEAD
) (
   input  logic              logic_clk_in,
   input  logic              logic_rst_in,
   input  logic              sched_enable,
   input  logic              slot_start,
   input  logic              slot_is_tx,
   input  logic [ADDR_W-1:0] tx_data_len,
   input  logic [ADDR_W-1:0] tx_freq_len,
   input  logic [ADDR_W-1:0] rx_freq_len,
   input  logic              sched_err_clr,
   output logic              tx_slot_interrupt,
   output logic              tx_rd_en,
   output logic [ADDR_W-1:0] tx_addr,
   output logic              tx_freq_rd_en,
   output logic [ADDR_W-1:0] tx_freq_addr,
   output logic              rx_slot_interrupt,
   output logic              rx_freq_pn_rd,
   output logic [ADDR_W-1:0] rx_freq_pn_addr,
   output logic              sched_busy,
   output logic              sched_done,
   output logic              sched_overrun
);

   localparam int LEAD_W = (IRQ_LEAD > 1) ? $clog2(IRQ_LEAD) : 1;

   sched_state_t      r_state;
   logic              r_is_tx;
   logic [ADDR_W-1:0] r_data_len;
   logic [ADDR_W-1:0] r_freq_len;
   logic [ADDR_W-1:0] r_rx_len;
   logic [LEAD_W-1:0] r_lead;
   logic              r_done;
   logic              r_overrun;

   sched_state_t      w_next_state;
   sched_state_t      w_phase;
   logic              w_accept;
   logic              w_launch;
   logic              w_advance;
   logic              w_finish;
   logic              w_bg_start;
   logic [ADDR_W-1:0] w_bg_len;
   logic              w_bg_strobe;
   logic [ADDR_W-1:0] w_bg_addr;
   logic              w_bg_done;

   assign w_accept  = (r_state == ST_IDLE) && slot_start;
   // The lead counter reaches zero one cycle before the first strobe slot.
   assign w_launch  = ((r_state == ST_IRQ) || (r_state == ST_LEAD)) && (r_lead == '0);
   assign w_advance = w_launch ||
                      (w_bg_done && (r_state inside {ST_TX_DATA, ST_TX_FREQ, ST_RX_FREQ}));

   always_comb begin
      // NOTE: every combinational output is defaulted first so no path can infer a latch.
      w_phase      = ST_IDLE;
      w_next_state = r_state;
      w_finish     = 1'b0;
      w_bg_start   = 1'b0;
      w_bg_len     = '0;
      if (w_launch)
         w_phase = first_phase(r_is_tx, r_data_len != '0, r_freq_len != '0, r_rx_len != '0);
      else if (r_state == ST_TX_DATA)
         w_phase = first_phase(1'b1, 1'b0, r_freq_len != '0, 1'b0);

      if (r_state == ST_IDLE) begin
         if (slot_start) w_next_state = ST_IRQ;
      end else if (w_advance) begin
         w_next_state = w_phase;
         w_finish     = (w_phase == ST_IDLE);
         w_bg_start   = (w_phase != ST_IDLE);
         case (w_phase)
            ST_TX_DATA: w_bg_len = r_data_len;
            ST_TX_FREQ: w_bg_len = r_freq_len;
            ST_RX_FREQ: w_bg_len = r_rx_len;
            default:    w_bg_len = '0;
         endcase
      end else if (r_state == ST_IRQ) begin
         w_next_state = ST_LEAD;
      end
   end

   always_ff @(posedge logic_clk_in) begin
      if (logic_rst_in) begin
         r_state    <= ST_IDLE;
         r_is_tx    <= 1'b0;
         r_data_len <= '0;
         r_freq_len <= '0;
         r_rx_len   <= '0;
         r_lead     <= '0;
         r_done     <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         if (slot_start && (r_state != ST_IDLE)) r_overrun <= 1'b1;
         else if (sched_err_clr)                 r_overrun <= 1'b0;

         if (!sched_enable) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_lead  <= '0;
         end else begin
            r_state <= w_next_state;
            r_done  <= w_finish;
            if (w_accept) begin
               r_is_tx    <= slot_is_tx;
               r_data_len <= tx_data_len;
               r_freq_len <= tx_freq_len;
               r_rx_len   <= rx_freq_len;
               r_lead     <= LEAD_W'(IRQ_LEAD - 1);
            end else if (r_lead != '0) begin
               r_lead <= r_lead - LEAD_W'(1);
            end
         end
      end
   end

   dsp_rd_burst_gen #(
      .ADDR_W (ADDR_W),
      .RD_GAP (RD_GAP)
   ) u_burst (
      .i_clk    (logic_clk_in),
      .i_rst    (logic_rst_in),
      .i_abort  (!sched_enable),
      .i_start  (w_bg_start),
      .i_len    (w_bg_len),
      .o_strobe (w_bg_strobe),
      .o_addr   (w_bg_addr),
      .o_done   (w_bg_done)
   );

   assign tx_slot_interrupt = (r_state == ST_IRQ) && r_is_tx;
   assign rx_slot_interrupt = (r_state == ST_IRQ) && !r_is_tx;
   assign tx_rd_en          = (r_state == ST_TX_DATA) && w_bg_strobe;
   assign tx_freq_rd_en     = (r_state == ST_TX_FREQ) && w_bg_strobe;
   assign rx_freq_pn_rd     = (r_state == ST_RX_FREQ) && w_bg_strobe;
   assign tx_addr           = tx_rd_en      ? w_bg_addr : '0;
   assign tx_freq_addr      = tx_freq_rd_en ? w_bg_addr : '0;
   assign rx_freq_pn_addr   = rx_freq_pn_rd ? w_bg_addr : '0;
   assign sched_busy        = (r_state != ST_IDLE);
   assign sched_done        = r_done;
   assign sched_overrun     = r_overrun;

endmodule

// File: tb/tb_dsp_slot_rd_sched.sv
// Self-checking bench for dsp_slot_rd_sched (RD_GAP=4, IRQ_LEAD=8): table-driven slot runs
// compared cycle by cycle, plus overrun, back-to-back, enable-abort and reset sequences.
module tb_dsp_slot_rd_sched;

   localparam int ADDR_W  = 10;
   localparam int MAX_CYC = 4200;

   logic              logic_clk_in = 1'b0;
   logic              logic_rst_in;
   logic              sched_enable;
   logic              slot_start;
   logic              slot_is_tx;
   logic [ADDR_W-1:0] tx_data_len;
   logic [ADDR_W-1:0] tx_freq_len;
   logic [ADDR_W-1:0] rx_freq_len;
   logic              sched_err_clr;
   logic              tx_slot_interrupt;
   logic              tx_rd_en;
   logic [ADDR_W-1:0] tx_addr;
   logic              tx_freq_rd_en;
   logic [ADDR_W-1:0] tx_freq_addr;
   logic              rx_slot_interrupt;
   logic              rx_freq_pn_rd;
   logic [ADDR_W-1:0] rx_freq_pn_addr;
   logic              sched_busy;
   logic              sched_done;
   logic              sched_overrun;

   always #5 logic_clk_in = ~logic_clk_in;

   dsp_slot_rd_sched #(
      .ADDR_W   (ADDR_W),
      .RD_GAP   (4),
      .IRQ_LEAD (8)
   ) dut (
      .logic_clk_in      (logic_clk_in),
      .logic_rst_in      (logic_rst_in),
      .sched_enable      (sched_enable),
      .slot_start        (slot_start),
      .slot_is_tx        (slot_is_tx),
      .tx_data_len       (tx_data_len),
      .tx_freq_len       (tx_freq_len),
      .rx_freq_len       (rx_freq_len),
      .sched_err_clr     (sched_err_clr),
      .tx_slot_interrupt (tx_slot_interrupt),
      .tx_rd_en          (tx_rd_en),
      .tx_addr           (tx_addr),
      .tx_freq_rd_en     (tx_freq_rd_en),
      .tx_freq_addr      (tx_freq_addr),
      .rx_slot_interrupt (rx_slot_interrupt),
      .rx_freq_pn_rd     (rx_freq_pn_rd),
      .rx_freq_pn_addr   (rx_freq_pn_addr),
      .sched_busy        (sched_busy),
      .sched_done        (sched_done),
      .sched_overrun     (sched_overrun)
   );

   // One slot run: inputs plus the hand-computed sched_done cycle.
   typedef struct {
      string name;
      bit    is_tx;
      int    dlen;
      int    flen;
      int    rlen;
      int    done;
   } slot_vec_t;

   logic [36:0] act     [MAX_CYC];
   bit          act_ovr [MAX_CYC];
   int          n_checks = 0;
   int          n_pass   = 0;

   function automatic slot_vec_t mk(input string name, input bit is_tx, input int dlen,
                                    input int flen, input int rlen, input int done);
      slot_vec_t v;
      v.name = name; v.is_tx = is_tx; v.dlen = dlen; v.flen = flen; v.rlen = rlen; v.done = done;
      return v;
   endfunction

   // Output order: tx_irq, tx_rd, tx_addr, txf_rd, txf_addr, rx_irq, rx_rd, rx_addr, busy, done.
   function automatic logic [36:0] dut_out();
      return {tx_slot_interrupt, tx_rd_en, tx_addr, tx_freq_rd_en, tx_freq_addr,
              rx_slot_interrupt, rx_freq_pn_rd, rx_freq_pn_addr, sched_busy, sched_done};
   endfunction

   // Expected outputs in cycle c of an undisturbed slot started in cycle 0.
   function automatic logic [36:0] model(input slot_vec_t v, input int c);
      logic              ti, tr, tfr, ri, rr, b, d;
      logic [ADDR_W-1:0] ta, tfa, ra;
      int                total, k;
      ti = 1'b0; tr = 1'b0; tfr = 1'b0; ri = 1'b0; rr = 1'b0;
      ta = '0; tfa = '0; ra = '0;
      total = v.is_tx ? (v.dlen + v.flen) : v.rlen;
      ti = v.is_tx && (c == 1);
      ri = !v.is_tx && (c == 1);
      b  = (c >= 1) && (c < v.done);
      d  = (c == v.done);
      if ((c >= 9) && (((c - 9) % 4) == 0)) begin
         k = (c - 9) / 4;
         if (k < total) begin
            if (!v.is_tx) begin
               rr = 1'b1; ra = ADDR_W'(k);
            end else if (k < v.dlen) begin
               tr = 1'b1; ta = ADDR_W'(k);
            end else begin
               tfr = 1'b1; tfa = ADDR_W'(k - v.dlen);
            end
         end
      end
      return {ti, tr, ta, tfr, tfa, ri, rr, ra, b, d};
   endfunction

   task automatic check(input string name, input logic [36:0] got, input logic [36:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, got, exp);
   endtask

   // Called just after a rising edge; cycle 0 is the slot_start cycle. Optional injections
   // (cycle index, -1 for none): extra slot_start, error clear, enable low, reset high.
   task automatic run_seq(input slot_vec_t v, input int n, input int x_start, input int clr_c,
                          input int dis_c, input int rst_c);
      slot_is_tx  = v.is_tx;
      tx_data_len = ADDR_W'(v.dlen);
      tx_freq_len = ADDR_W'(v.flen);
      rx_freq_len = ADDR_W'(v.rlen);
      for (int c = 0; c < n; c++) begin
         slot_start    = (c == 0) || (c == x_start);
         sched_err_clr = (c == clr_c);
         sched_enable  = (c != dis_c);
         logic_rst_in  = (c == rst_c);
         @(negedge logic_clk_in);
         act[c]     = dut_out();
         act_ovr[c] = sched_overrun;
         @(posedge logic_clk_in);
         #1;
      end
      slot_start    = 1'b0;
      sched_err_clr = 1'b0;
      sched_enable  = 1'b1;
      logic_rst_in  = 1'b0;
   endtask

   // Compare a recorded run against the model; after cycle cut all outputs must be 0, and after
   // cycle shift (if >= 0) a second slot restarted at that cycle is expected.
   task automatic cmp_run(input slot_vec_t v, input string tag, input int n, input int cut,
                          input int shift);
      logic [36:0] exp;
      for (int c = 0; c < n; c++) begin
         if (c > cut)                        exp = '0;
         else if ((shift >= 0) && (c > shift)) exp = model(v, c - shift);
         else                                exp = model(v, c);
         check($sformatf("%s c%0d", tag, c), act[c], exp);
      end
   endtask

   task automatic check_ovr(input string tag, input int c, input bit exp);
      check($sformatf("%s ovr c%0d", tag, c), {36'b0, act_ovr[c]}, {36'b0, exp});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      slot_vec_t vecs [8];
      slot_vec_t v1, v2, v3;

      vecs[0] = mk("tx_3_2",  1'b1, 3, 2, 0,    29);
      vecs[1] = mk("rx_4",    1'b0, 5, 6, 4,    25);
      vecs[2] = mk("tx_0_0",  1'b1, 0, 0, 7,     9);
      vecs[3] = mk("tx_0_2",  1'b1, 0, 2, 0,    17);
      vecs[4] = mk("tx_1_0",  1'b1, 1, 0, 0,    13);
      vecs[5] = mk("rx_0",    1'b0, 3, 3, 0,     9);
      vecs[6] = mk("tx_2_1",  1'b1, 2, 1, 0,    21);
      vecs[7] = mk("rx_max",  1'b0, 0, 0, 1023, 4101);
      v1 = vecs[0];
      v2 = vecs[1];
      v3 = vecs[2];

      logic_rst_in  = 1'b1;
      sched_enable  = 1'b1;
      slot_start    = 1'b0;
      slot_is_tx    = 1'b0;
      tx_data_len   = '0;
      tx_freq_len   = '0;
      rx_freq_len   = '0;
      sched_err_clr = 1'b0;
      repeat (3) @(posedge logic_clk_in);
      @(negedge logic_clk_in);
      check("reset outputs", dut_out(), '0);
      check("reset overrun", {36'b0, sched_overrun}, '0);
      @(posedge logic_clk_in);
      #1;
      logic_rst_in = 1'b0;
      @(negedge logic_clk_in);
      check("idle outputs", dut_out(), '0);
      @(posedge logic_clk_in);
      #1;

      for (int i = 0; i < 8; i++) begin
         run_seq(vecs[i], vecs[i].done + 3, -1, -1, -1, -1);
         cmp_run(vecs[i], vecs[i].name, vecs[i].done + 3, MAX_CYC, -1);
      end

      // Back-to-back: a start in the done cycle is accepted and runs a second slot.
      run_seq(v3, 22, 9, -1, -1, -1);
      cmp_run(v3, "b2b", 22, MAX_CYC, 9);
      check_ovr("b2b", 10, 1'b0);

      // Overrun: start while busy sets it from the next cycle; clear at 40 drops it at 41.
      run_seq(v1, 45, 5, 40, -1, -1);
      cmp_run(v1, "ovr", 45, MAX_CYC, -1);
      check_ovr("ovr", 5, 1'b0);
      check_ovr("ovr", 6, 1'b1);
      check_ovr("ovr", 29, 1'b1);
      check_ovr("ovr", 40, 1'b1);
      check_ovr("ovr", 41, 1'b0);

      // Set wins over a simultaneous clear.
      run_seq(v1, 32, 20, 20, -1, -1);
      cmp_run(v1, "setwin", 32, MAX_CYC, -1);
      check_ovr("setwin", 20, 1'b0);
      check_ovr("setwin", 21, 1'b1);

      // Enable low in cycle 14 aborts; overrun survives; the next slot runs normally.
      run_seq(v1, 40, -1, -1, 14, -1);
      cmp_run(v1, "dis", 40, 14, -1);
      check_ovr("dis", 15, 1'b1);
      check_ovr("dis", 39, 1'b1);
      run_seq(v1, 32, -1, -1, -1, -1);
      cmp_run(v1, "dis_next", 32, MAX_CYC, -1);

      // Reset in cycle 12 aborts an RX slot and clears overrun; restart matches a clean run.
      run_seq(v2, 30, -1, -1, -1, 12);
      cmp_run(v2, "rst", 30, 12, -1);
      check_ovr("rst", 12, 1'b1);
      check_ovr("rst", 13, 1'b0);
      run_seq(v2, 28, -1, -1, -1, -1);
      cmp_run(v2, "rst_next", 28, MAX_CYC, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
